// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a flop word memory: programmable OKAY wait states,
// little-endian byte/halfword/word lanes and two-cycle ERROR responses.
module ahb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 32,
    parameter int          WAIT_STATES = 1
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic        Hwrite,
    input  logic [2:0]  Hsize,
    input  logic [2:0]  Hburst,
    input  logic        Hreadyin,
    input  logic [31:0] Hwdata,
    output logic        Hreadyout,
    output logic        Hresp,
    output logic [31:0] Hrdata
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [1:0] WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          active_q, err_q, write_q;
    logic [31:0]   addr_q;
    logic [2:0]    size_q;
    logic [31:0]   mem_q [DEPTH];

    logic          rdy, accept, legal, commit;
    logic [AW-1:0] idx;
    logic [3:0]    lane_en;
    logic          unused_ok;

    // Only the states that end a data phase (or have none) can take a new address.
    assign rdy    = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
    assign accept = rdy && Hreadyin && Htrans[1];

    // Base is aligned to the window size, so the range check is an upper-bit match.
    assign legal = (Haddr[31:AW+2] == BASE_ADDR[31:AW+2])
                && (Hsize <= 3'd2)
                && !((Hsize == 3'd1) && Haddr[0])
                && !((Hsize == 3'd2) && (Haddr[1:0] != 2'b00));

    assign idx       = addr_q[AW+1:2];
    assign commit    = (state_q == S_DONE) && active_q && write_q && !err_q;
    assign Hreadyout = rdy;
    assign Hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign Hrdata    = ((state_q == S_DONE) && active_q && !write_q) ? mem_q[idx] : 32'h0;
    assign unused_ok = ^{Hburst, Htrans[0], addr_q[31:AW+2]};

    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            3'd0:    lane_en[addr_q[1:0]] = 1'b1;
            3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 2'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                if (accept) begin
                    if (!legal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            active_q <= 1'b0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= 32'h0;
            size_q   <= 3'd0;
        end else if (rdy) begin
            active_q <= accept;
            if (accept) begin
                addr_q  <= Haddr;
                write_q <= Hwrite;
                size_q  <= Hsize;
                err_q   <= !legal;
            end
        end
    end

    // Commit lands on the edge closing DONE, so a pipelined read sees it.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
        end else if (commit) begin
            for (int n = 0; n < 4; n++)
                if (lane_en[n]) mem_q[idx][8*n +: 8] <= Hwdata[8*n +: 8];
        end
    end
endmodule
